// File: rtl/counter_pkg.sv
// Shared types and default sizes for the multi-channel counter.
// Imported by counter_ch, counter_multi_ch and the bench.
package counter_pkg;

   localparam int DEF_WIDTH  = 8;
   localparam int DEF_NUM_CH = 4;

   // Boundary behaviour, cast directly from the sat_mode pin
   typedef enum logic {
      CNT_WRAP = 1'b0,
      CNT_SAT  = 1'b1
   } cnt_mode_e;

   // Direction encoding on up_dn
   localparam logic CNT_UP = 1'b1;
   localparam logic CNT_DN = 1'b0;

endpackage

// File: rtl/counter_ch.sv
// One counter channel: count, tc and sticky ovf registers.
// Ports: clk, rst (sync, active low), en, up_dn, load, load_val,
//   limit, mode, clr_ovf in; count, tc, ovf registered out.
module counter_ch
   import counter_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] limit,
   input  cnt_mode_e        mode,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             ovf
);

   logic [WIDTH-1:0] count_nxt;
   logic             at_bound;

   // Boundary compare is done before the +/-1, so the
   // arithmetic never carries or borrows out of WIDTH.
   // Using >= also catches a count stranded above a
   // freshly lowered limit.
   always_comb begin
      count_nxt = count;
      at_bound  = 1'b0;
      if (load) begin
         count_nxt = (load_val > limit) ? limit : load_val;
      end else if (en) begin
         if (up_dn == CNT_UP) begin
            if (count >= limit) begin
               at_bound  = 1'b1;
               count_nxt = (mode == CNT_SAT) ? limit : '0;
            end else begin
               count_nxt = count + 1'b1;
            end
         end else begin
            if (count == '0) begin
               at_bound  = 1'b1;
               count_nxt = (mode == CNT_SAT) ? '0 : limit;
            end else begin
               count_nxt = count - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
         tc    <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         count <= count_nxt;
         tc    <= at_bound;
         // A new event beats a clear in the same cycle
         if (at_bound)
            ovf <= 1'b1;
         else if (clr_ovf)
            ovf <= 1'b0;
      end
   end

endmodule

// File: rtl/counter_multi_ch.sv
// NUM_CH independent up/down counters sharing limit and mode.
// Ports: clk, rst (sync, active low), per-channel en, up_dn, load,
//   clr_ovf, packed load_val; shared limit, sat_mode;
//   out packed count, per-channel tc and sticky ovf.
module counter_multi_ch
   import counter_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int NUM_CH = DEF_NUM_CH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       en,
   input  logic [NUM_CH-1:0]       up_dn,
   input  logic [NUM_CH-1:0]       load,
   input  logic [NUM_CH*WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0]        limit,
   input  logic                    sat_mode,
   input  logic [NUM_CH-1:0]       clr_ovf,
   output logic [NUM_CH*WIDTH-1:0] count,
   output logic [NUM_CH-1:0]       tc,
   output logic [NUM_CH-1:0]       ovf
);

   cnt_mode_e mode;

   assign mode = cnt_mode_e'(sat_mode);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      counter_ch #(
         .WIDTH(WIDTH)
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .en      (en[i]),
         .up_dn   (up_dn[i]),
         .load    (load[i]),
         .load_val(load_val[i*WIDTH +: WIDTH]),
         .limit   (limit),
         .mode    (mode),
         .clr_ovf (clr_ovf[i]),
         .count   (count[i*WIDTH +: WIDTH]),
         .tc      (tc[i]),
         .ovf     (ovf[i])
      );
   end

endmodule

// File: tb/tb_counter_multi_ch.sv
// Scoreboard bench for counter_multi_ch: directed plan plus random.
// Driver pushes model results; monitor pops and compares each cycle.
module tb_counter_multi_ch;
   import counter_pkg::*;

   localparam int W  = DEF_WIDTH;
   localparam int NC = DEF_NUM_CH;

   typedef struct {
      logic [NC*W-1:0] count;
      logic [NC-1:0]   tc;
      logic [NC-1:0]   ovf;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst;
   logic [NC-1:0]   en, up_dn, load, clr_ovf;
   logic [NC*W-1:0] load_val;
   logic [W-1:0]    limit;
   logic            sat_mode;
   logic [NC*W-1:0] count;
   logic [NC-1:0]   tc, ovf;

   exp_t q[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Reference state, plain integers
   int m_cnt[NC];
   bit m_tc[NC];
   bit m_ovf[NC];

   counter_multi_ch #(.WIDTH(W), .NUM_CH(NC)) dut (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn),
      .load(load), .load_val(load_val), .limit(limit),
      .sat_mode(sat_mode), .clr_ovf(clr_ovf),
      .count(count), .tc(tc), .ovf(ovf)
   );

   always #5 clk = ~clk;

   function automatic logic [NC*W-1:0] lv4(int a, int b, int c, int d);
      logic [NC*W-1:0] v;
      v = '0;
      v[0*W +: W] = W'(a);
      v[1*W +: W] = W'(b);
      v[2*W +: W] = W'(c);
      v[3*W +: W] = W'(d);
      return v;
   endfunction

   // Drive one cycle of inputs at negedge and push the response
   // the next rising edge must produce.
   task automatic apply(input bit r, input logic [NC-1:0] e,
                        input logic [NC-1:0] u, input logic [NC-1:0] l,
                        input logic [NC*W-1:0] v, input int lim,
                        input bit s, input logic [NC-1:0] c);
      exp_t x;
      @(negedge clk);
      rst = r; en = e; up_dn = u; load = l; load_val = v;
      limit = W'(lim); sat_mode = s; clr_ovf = c;
      for (int i = 0; i < NC; i++) begin
         int lvi;
         bit b;
         lvi = int'(v[i*W +: W]);
         b = 0;
         if (!r) begin
            m_cnt[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
            continue;
         end
         if (l[i]) begin
            m_cnt[i] = (lvi < lim) ? lvi : lim;
         end else if (e[i]) begin
            if (u[i]) begin
               if (m_cnt[i] + 1 > lim) begin
                  b = 1;
                  m_cnt[i] = s ? lim : 0;
               end else m_cnt[i] = m_cnt[i] + 1;
            end else begin
               if (m_cnt[i] - 1 < 0) begin
                  b = 1;
                  m_cnt[i] = s ? 0 : lim;
               end else m_cnt[i] = m_cnt[i] - 1;
            end
         end
         m_tc[i] = b;
         if (b) m_ovf[i] = 1;
         else if (c[i]) m_ovf[i] = 0;
      end
      for (int i = 0; i < NC; i++) begin
         x.count[i*W +: W] = W'(m_cnt[i]);
         x.tc[i] = m_tc[i];
         x.ovf[i] = m_ovf[i];
      end
      q.push_back(x);
   endtask

   // Monitor: outputs are valid every cycle once stimulus starts
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() != 0) begin
            x = q.pop_front();
            vectors++;
            if (count !== x.count || tc !== x.tc || ovf !== x.ovf) begin
               miscompares++;
               $display("FAIL vec%0d: count=%h tc=%b ovf=%b, expected count=%h tc=%b ovf=%b",
                        vectors, count, tc, ovf, x.count, x.tc, x.ovf);
            end
         end
      end
   end

   initial begin
      int wait_cyc;
      rst = 1'b0; en = '0; up_dn = '0; load = '0; load_val = '0;
      limit = '0; sat_mode = 1'b0; clr_ovf = '0;
      for (int i = 0; i < NC; i++) begin
         m_cnt[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
      end

      // Reset overrides en and load
      apply(0, 4'hF, 4'hF, 4'hF, lv4(3, 3, 3, 3), 5, 0, 4'h0);
      apply(0, 4'hF, 4'hF, 4'hF, lv4(3, 3, 3, 3), 5, 0, 4'h0);
      apply(1, 4'hF, 4'hF, 4'h0, '0, 5, 0, 4'h0);
      apply(0, 4'h0, 4'h0, 4'h0, '0, 5, 0, 4'h0);

      // Up wrap on ch0: 1,2,3,4,5,0,1
      repeat (7) apply(1, 4'h1, 4'h1, 4'h0, '0, 5, 0, 4'h0);

      // Down saturate on ch1 from 2: 1,0,0,0
      apply(1, 4'h0, 4'h0, 4'h2, lv4(0, 2, 0, 0), 5, 1, 4'h0);
      repeat (4) apply(1, 4'h2, 4'h0, 4'h0, '0, 5, 1, 4'h0);

      // Load clamp, load beats en
      apply(1, 4'h4, 4'h4, 4'h4, lv4(0, 0, 200, 0), 10, 0, 4'h0);

      // Limit shrink below count, wrap then saturate
      apply(1, 4'h0, 4'h0, 4'h8, lv4(0, 0, 0, 9), 10, 0, 4'h0);
      apply(1, 4'h8, 4'h8, 4'h0, '0, 4, 0, 4'h0);
      apply(1, 4'h0, 4'h0, 4'h8, lv4(0, 0, 0, 9), 10, 1, 4'h0);
      apply(1, 4'h8, 4'h8, 4'h0, '0, 4, 1, 4'h0);
      // Down from above limit decrements normally
      apply(1, 4'h0, 4'h0, 4'h8, lv4(0, 0, 0, 9), 10, 0, 4'h0);
      apply(1, 4'h8, 4'h0, 4'h0, '0, 4, 0, 4'h0);

      // ovf clear race on ch0, then a lone clear
      apply(1, 4'h0, 4'h0, 4'h1, lv4(4, 0, 0, 0), 4, 0, 4'h0);
      apply(1, 4'h1, 4'h1, 4'h0, '0, 4, 0, 4'h1);
      apply(1, 4'h0, 4'h0, 4'h0, '0, 4, 0, 4'h1);
      apply(1, 4'h0, 4'h0, 4'h0, '0, 4, 0, 4'h0);

      // limit = 0: every step is a boundary
      repeat (3) apply(1, 4'hF, 4'h5, 4'h0, '0, 0, 0, 4'h0);
      repeat (3) apply(1, 4'hF, 4'hA, 4'h0, '0, 0, 1, 4'h0);

      // Random traffic
      repeat (600) begin
         logic [NC-1:0] e, u, l, c;
         int lim;
         for (int i = 0; i < NC; i++) begin
            e[i] = ($urandom_range(0, 3) != 0);
            u[i] = $urandom_range(0, 1) == 1;
            l[i] = ($urandom_range(0, 7) == 0);
            c[i] = ($urandom_range(0, 7) == 0);
         end
         lim = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3)
                                           : $urandom_range(0, 255);
         apply(($urandom_range(0, 49) != 0), e, u, l,
               NC*W'($urandom), lim, $urandom_range(0, 1) == 1, c);
      end

      wait_cyc = 0;
      while (q.size() != 0 && wait_cyc < 10) begin
         @(posedge clk);
         wait_cyc++;
      end
      #2;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d pending, expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/counter_multi_ch.md
Name: counter_multi_ch

Overview:
- Parametrised multi-channel up/down counter; next-generation replacement for the single fixed-width counter DUT.
- NUM_CH independent channels, each WIDTH bits, sharing a runtime limit and a wrap/saturate mode.
- Per-channel enable, direction, synchronous load, boundary (terminal-count) pulse and sticky overflow flag.
- Sits behind the counter interface; the bench drives it via the virtual interface in the existing counter environment.

Parameters:
- WIDTH, 8, bit width of each channel count.
- NUM_CH, 4, number of independent channels (>=1).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous active-low reset; when 0 at a rising edge, all state is reset.
- en  in  NUM_CH  per-channel count enable.
- up_dn  in  NUM_CH  per-channel direction: 1 = up, 0 = down.
- load  in  NUM_CH  per-channel synchronous load strobe.
- load_val  in  NUM_CH*WIDTH  load values; channel i uses bits [i*WIDTH +: WIDTH].
- limit  in  WIDTH  shared upper bound; count range is 0..limit inclusive.
- sat_mode  in  1  0 = wrap mode, 1 = saturate mode (shared).
- clr_ovf  in  NUM_CH  per-channel sticky-overflow clear.
- count  out  NUM_CH*WIDTH  registered channel counts, packed as load_val.
- tc  out  NUM_CH  registered one-cycle boundary-event pulse.
- ovf  out  NUM_CH  registered sticky boundary-event flag.

Behaviour:
- Reset:
  - rst=0 at a rising edge sets count=0, tc=0 and ovf=0 for all channels.
  - Reset overrides every other input, including mid-count and mid-load.
- Per-channel priority, evaluated each edge: rst, then load, then en, then hold.
- Load:
  - count <= min(load_val_i, limit).
  - tc_i <= 0. Load does not set ovf.
- Step, when en_i=1 and load_i=0. All outputs are registered; the count updates 1 cycle after en is sampled.
  - Up, count < limit: count+1.
  - Up, count >= limit (boundary): wrap mode gives count <= 0; saturate mode gives count <= limit.
  - Down, count > 0: count-1.
  - Down, count == 0 (boundary): wrap mode gives count <= limit; saturate mode holds 0.
  - Any boundary step sets tc_i <= 1 for that one cycle and sets ovf_i <= 1.
  - A non-boundary step gives tc_i <= 0.
- Hold (en_i=0, load_i=0): count unchanged, tc_i <= 0.
- ovf:
  - Sticky until clr_ovf_i=1.
  - A boundary event and clr_ovf in the same cycle leaves ovf=1 (set wins).
- limit changes:
  - limit may change at any cycle; no internal copy is kept.
  - If count > limit after a change, the next up step is a boundary event.
  - A down step from count > limit decrements normally.
- limit = 0: every step is a boundary event. Wrap and saturate both yield 0, and tc pulses on every enabled cycle.
- Arithmetic: WIDTH-bit unsigned; no carry out of WIDTH is ever produced, because the boundary compare precedes the increment.
- Channels are fully independent; simultaneous events on different channels do not interact.

Decomposition:
- Package counter_pkg:
  - cnt_mode_e enum {CNT_WRAP=0, CNT_SAT=1}, cast from sat_mode.
  - Direction constants CNT_UP=1, CNT_DN=0.
  - Default WIDTH and NUM_CH localparams shared with counter_cfg and the bench.
- Sub-module counter_ch:
  - One channel: count, tc and ovf registers plus boundary logic.
  - counter_multi_ch is a generate loop of NUM_CH counter_ch instances plus packing and unpacking of the vectors.

Test Plan (WIDTH=8, NUM_CH=4):
- Reset: hold rst=0 for 2 edges with en=4'hF, load=4'hF -> count=0, tc=0, ovf=0 on all channels. Release rst -> first increment appears 1 cycle later.
- Up wrap: limit=5, sat_mode=0, ch0 up, 7 enabled cycles -> count 1,2,3,4,5,0,1. tc0 high only the cycle count shows 0. ovf0=1 thereafter.
- Down saturate: limit=5, sat_mode=1, ch1 loaded with 2, then 4 down cycles -> count 1,0,0,0. tc1 pulses on the 3rd and 4th steps.
- Load clamp and priority: limit=10, load_val ch2=200 with load=1 and en=1 simultaneously -> count2=10, tc2=0, ovf2 unchanged.
- Limit shrink: ch3 at 9, limit changed to 4, one up step -> wrap mode gives 0 (saturate mode gives 4); tc3=1.
- ovf clear race: clr_ovf0=1 in the same cycle as a boundary step -> ovf0 stays 1. clr_ovf0=1 alone next cycle -> ovf0=0. Other channels are unaffected.
